// File: rtl/mem_port_pkg.sv
// Shared encodings for the data-side memory port: access sizes, FSM states
// and the alignment rule used to reject a request before it reaches the ram.
package mem_port_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  // True when the request must be answered with an error and no ram access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: extracts and extends sub-word load data and
// merges sub-word store data into the word read back from ram.
module mem_lane_align
  import mem_port_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    sel_byte   = ram_word[7:0];
    sel_half   = ram_word[15:0];
    load_data  = ram_word;
    store_word = ram_word;

    case (addr_lo)
      2'd0:    sel_byte = ram_word[7:0];
      2'd1:    sel_byte = ram_word[15:8];
      2'd2:    sel_byte = ram_word[23:16];
      default: sel_byte = ram_word[31:24];
    endcase
    sel_half = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_data = ram_word;
    endcase

    // Only the addressed lane is replaced; the rest of the word is preserved.
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Data-side memory initiator: one load/store at a time from the MEM stage,
// driving a word-wide ram with read-modify-write for byte and half stores.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH+1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  logic [1:0]            state;
  logic                  req_we;
  logic                  req_signed;
  logic [1:0]            req_size;
  logic [1:0]            req_lo;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;

  logic                  accept;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign accept  = i_req_valid && (state == ST_IDLE);
  assign req_bad = misaligned(i_req_size, i_req_addr[1:0]);

  mem_lane_align u_align (
    .addr_lo    (req_lo),
    .size       (req_size),
    .sign_ext   (req_signed),
    .ram_word   (i_ram_data),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      req_we     <= 1'b0;
      req_signed <= 1'b0;
      req_size   <= SZ_BYTE;
      req_lo     <= 2'b00;
      req_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_we     <= i_req_we;
            req_signed <= i_req_signed;
            req_size   <= i_req_size;
            req_lo     <= i_req_addr[1:0];
            req_wdata  <= i_req_wdata;
            rsp_rdata  <= '0;
            rsp_err    <= req_bad;
            if (req_bad) begin
              state <= ST_RESP;
            end else begin
              ram_addr <= i_req_addr[ADDR_WIDTH+1:2];
              if (i_req_we) ram_data <= i_req_wdata;
              // A full-word store needs no read; everything else reads first.
              if (i_req_we && (i_req_size == SZ_WORD)) state <= ST_WR;
              else                                     state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (req_we) begin
            ram_data <= store_word;
            state    <= ST_WR;
          end else begin
            rsp_rdata <= load_data;
            state     <= ST_RESP;
          end
        end
        ST_WR: begin
          state <= ST_RESP;
        end
        default: begin
          if (i_rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write enable decodes straight from state so an async reset removes it
  // immediately and a store cut short by reset never reaches the ram.
  assign o_ram_we    = (state == ST_WR);
  assign o_req_ready = (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;
  assign o_ram_addr  = ram_addr;
  assign o_ram_data  = ram_data;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl with a combinational-read ram model; expected
// responses go to a scoreboard queue when requested and are popped on response.
module tb_mem_port_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_pulses;
    logic [4:0]  word;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  logic [31:0] mem [32] = '{default: 32'h0};
  int          we_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];

  always #50 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      we_cnt        <= we_cnt + 1;
    end
  end

  mem_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_size   (req_size),
    .i_req_signed (req_signed),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_ram_addr   (ram_addr),
    .o_ram_data   (ram_data),
    .o_ram_we     (ram_we),
    .i_ram_data   (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request, optionally stalls the response for 'hold' cycles,
  // then checks the popped expectation against what the DUT returned.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [6:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_we, input int hold);
    exp_t e;
    int   lat;
    int   we0;
    e.name = name; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    e.we_pulses = exp_we; e.word = addr[6:2];
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    we0 = we_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hDEAD_BEEF;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    check({e.name, ".lat"}, lat, e.lat);
    check({e.name, ".rdata"}, rsp_rdata, e.rdata);
    check({e.name, ".err"}, {31'b0, rsp_err}, {31'b0, e.err});
    check({e.name, ".we_pulses"}, we_cnt - we0, e.we_pulses);
    if (!e.err) check({e.name, ".ram_addr"}, {27'b0, ram_addr}, {27'b0, e.word});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({e.name, ".hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({e.name, ".hold_rdata"}, rsp_rdata, e.rdata);
      check({e.name, ".hold_err"}, {31'b0, rsp_err}, {31'b0, e.err});
      check({e.name, ".hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    if (hold != 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({e.name, ".done_ready"}, {31'b0, req_ready}, 32'd1);
    check({e.name, ".done_valid"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] snap0;
    logic [31:0] snap1;
    int          we_before;

    // 1: reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, req_ready}, 32'd1);
    check("rst.ram_we", {31'b0, ram_we}, 32'd0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    check("rst.ram_addr", {27'b0, ram_addr}, 32'd0);
    check("rst.ram_data", ram_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: word store and load
    do_req("sw08", 1'b1, 2'b10, 1'b0, 7'h08, 32'h1111_2222, 32'h0, 1'b0, 2, 1, 0);
    check("mem2", mem[2], 32'h1111_2222);
    do_req("lw08", 1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'h1111_2222, 1'b0, 2, 0, 0);

    // 3: byte store with read-modify-write, signed/unsigned byte loads
    do_req("sw0c", 1'b1, 2'b10, 1'b0, 7'h0C, 32'h4444_4444, 32'h0, 1'b0, 2, 1, 0);
    do_req("sb0d", 1'b1, 2'b00, 1'b0, 7'h0D, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 0);
    check("mem3", mem[3], 32'h4444_AB44);
    do_req("lb0d", 1'b0, 2'b00, 1'b1, 7'h0D, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 0, 0);
    do_req("lbu0d", 1'b0, 2'b00, 1'b0, 7'h0D, 32'h0, 32'h0000_00AB, 1'b0, 2, 0, 0);

    // 4: upper half store, signed/unsigned half loads
    do_req("sw10", 1'b1, 2'b10, 1'b0, 7'h10, 32'h0, 32'h0, 1'b0, 2, 1, 0);
    do_req("sh12", 1'b1, 2'b01, 1'b0, 7'h12, 32'h0000_8001, 32'h0, 1'b0, 3, 1, 0);
    check("mem4", mem[4], 32'h8001_0000);
    do_req("lh12", 1'b0, 2'b01, 1'b1, 7'h12, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0, 0);
    do_req("lhu12", 1'b0, 2'b01, 1'b0, 7'h12, 32'h0, 32'h0000_8001, 1'b0, 2, 0, 0);

    // 5: misaligned / illegal requests
    snap0 = mem[0];
    snap1 = mem[1];
    do_req("lw05", 1'b0, 2'b10, 1'b0, 7'h05, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("lh03", 1'b0, 2'b01, 1'b1, 7'h03, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("sz3", 1'b1, 2'b11, 1'b0, 7'h00, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 0);
    check("mem0_kept", mem[0], snap0);
    check("mem1_kept", mem[1], snap1);

    // 6a: response back-pressure
    do_req("lw08_hold", 1'b0, 2'b10, 1'b0, 7'h08, 32'h0, 32'h1111_2222, 1'b0, 2, 0, 5);

    // 6b: reset during the read phase of a byte store
    do_req("sw18", 1'b1, 2'b10, 1'b0, 7'h18, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 0);
    we_before = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 7'h18; req_wdata = 32'h0000_00CD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort.rd_we", {31'b0, ram_we}, 32'd0);
    check("abort.rd_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.we", {31'b0, ram_we}, 32'd0);
    check("abort.ready", {31'b0, req_ready}, 32'd1);
    check("abort.valid", {31'b0, rsp_valid}, 32'd0);
    check("abort.ram_data", ram_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort.mem6", mem[6], 32'h1234_5678);
    check("abort.we_cnt", we_cnt - we_before, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("lw18", 1'b0, 2'b10, 1'b0, 7'h18, 32'h0, 32'h1234_5678, 1'b0, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
